// File: rtl/column_scheduler_if.sv
// Bundle between the game state machine, the column scheduler and the three letter columns.
// The scheduler attaches through the slave modport; the game/column side drives through master.
interface column_scheduler_if;
  logic       enable;
  logic [7:0] score;
  logic [2:0] col_busy;
  logic [2:0] correct;
  logic [2:0] game_over;
  logic       fall_tick;
  logic [2:0] spawn;
  logic [7:0] spawn_letter;
  logic       score_inc;
  logic       running;

  modport master (
    output enable, score, col_busy, correct, game_over,
    input  fall_tick, spawn, spawn_letter, score_inc, running
  );

  modport slave (
    input  enable, score, col_busy, correct, game_over,
    output fall_tick, spawn, spawn_letter, score_inc, running
  );
endinterface

// File: rtl/column_scheduler.sv
// Flippy Bit column scheduler: fall-tick divider, round-robin letter spawner and
// score-pulse serializer, gated by an IDLE/RUN/HALT state machine.
module column_scheduler #(
  parameter int unsigned TICK_DIV   = 32'd2500000,
  parameter int unsigned MIN_DIV    = 32'd500000,
  parameter int unsigned DIV_STEP   = 32'd100000,
  parameter int unsigned SCORE_STEP = 32'd8,
  parameter int unsigned SPAWN_GAP  = 32'd6,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input logic clock,
  input logic reset_signal,
  column_scheduler_if.slave bus
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [31:0] TICK_DIV_W   = 32'(TICK_DIV);
  localparam logic [31:0] MIN_DIV_W    = 32'(MIN_DIV);
  localparam logic [31:0] DIV_STEP_W   = 32'(DIV_STEP);
  localparam logic [31:0] SCORE_STEP_W = 32'(SCORE_STEP);
  localparam logic [7:0]  SPAWN_GAP_W  = 8'(SPAWN_GAP);

  // Fibonacci LFSR for x^8+x^6+x^5+x^4+1.
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    lfsr_step = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [1:0] next_col(input logic [1:0] c);
    case (c)
      2'd0:    next_col = 2'd1;
      2'd1:    next_col = 2'd2;
      default: next_col = 2'd0;
    endcase
  endfunction

  logic [1:0]  state_r;
  logic [7:0]  lfsr_r;
  logic [31:0] div_cnt_r;
  logic [31:0] cur_div_r;
  logic [7:0]  gap_cnt_r;
  logic [1:0]  last_spawn_r;
  logic [2:0]  pending_r;
  logic        fall_tick_r;
  logic [2:0]  spawn_r;
  logic [7:0]  spawn_letter_r;
  logic        score_inc_r;
  logic        running_r;

  logic [31:0] level_s;
  logic [31:0] reduction_s;
  logic [31:0] target_s;
  logic [3:0]  free_s;
  logic [1:0]  c1_s;
  logic [1:0]  c2_s;
  logic [1:0]  c3_s;
  logic [1:0]  pick_s;
  logic        found_s;
  logic        spawn_go_s;
  logic [2:0]  set_s;
  logic [2:0]  clr_s;
  logic [2:0]  pending_next_s;

  // Next fall-tick period from the score, saturating at the floor.
  always_comb begin
    level_s     = {24'd0, bus.score} / SCORE_STEP_W;
    reduction_s = level_s * DIV_STEP_W;
    if (reduction_s > (TICK_DIV_W - MIN_DIV_W)) begin
      target_s = MIN_DIV_W;
    end else begin
      target_s = TICK_DIV_W - reduction_s;
    end
  end

  assign free_s = {1'b0, ~bus.col_busy};
  assign c1_s   = next_col(last_spawn_r);
  assign c2_s   = next_col(c1_s);
  assign c3_s   = next_col(c2_s);

  // First free column searching upward from the one after the last spawn.
  always_comb begin
    found_s = 1'b1;
    if (free_s[c1_s]) begin
      pick_s = c1_s;
    end else if (free_s[c2_s]) begin
      pick_s = c2_s;
    end else if (free_s[c3_s]) begin
      pick_s = c3_s;
    end else begin
      pick_s  = c1_s;
      found_s = 1'b0;
    end
  end

  assign spawn_go_s = (gap_cnt_r == SPAWN_GAP_W) && found_s;

  // Score arbiter: a pulse on an already-pending bit merges, so set and clear never collide.
  always_comb begin
    clr_s = pending_r & (~pending_r + 3'd1);
    if ((state_r == ST_RUN) || (state_r == ST_HALT)) begin
      set_s = bus.correct & ~pending_r;
    end else begin
      set_s = 3'b000;
    end
    if ((state_r == ST_HALT) && !bus.enable) begin
      pending_next_s = 3'b000;
    end else begin
      pending_next_s = (pending_r & ~clr_s) | set_s;
    end
  end

  // State machine, divider, spawner and registered outputs.
  always_ff @(posedge clock or posedge reset_signal) begin
    if (reset_signal) begin
      state_r        <= ST_IDLE;
      lfsr_r         <= LFSR_SEED;
      div_cnt_r      <= 32'd0;
      cur_div_r      <= TICK_DIV_W;
      gap_cnt_r      <= 8'd0;
      last_spawn_r   <= 2'd2;
      pending_r      <= 3'b000;
      fall_tick_r    <= 1'b0;
      spawn_r        <= 3'b000;
      spawn_letter_r <= 8'd0;
      score_inc_r    <= 1'b0;
      running_r      <= 1'b0;
    end else begin
      lfsr_r      <= lfsr_step(lfsr_r);
      pending_r   <= pending_next_s;
      score_inc_r <= |pending_r;
      fall_tick_r <= 1'b0;
      spawn_r     <= 3'b000;
      case (state_r)
        ST_IDLE: begin
          if (bus.enable) begin
            state_r   <= ST_RUN;
            running_r <= 1'b1;
            div_cnt_r <= 32'd0;
            gap_cnt_r <= 8'd0;
            cur_div_r <= TICK_DIV_W;
          end else begin
            running_r <= 1'b0;
          end
        end
        ST_RUN: begin
          if (|bus.game_over) begin
            state_r   <= ST_HALT;
            running_r <= 1'b0;
          end else begin
            // The new period is sampled only at a tick so a score change cannot cut one short.
            if (div_cnt_r == (cur_div_r - 32'd1)) begin
              fall_tick_r <= 1'b1;
              div_cnt_r   <= 32'd0;
              cur_div_r   <= target_s;
            end else begin
              div_cnt_r <= div_cnt_r + 32'd1;
            end
            if (spawn_go_s) begin
              spawn_r        <= 3'b001 << pick_s;
              spawn_letter_r <= lfsr_r;
              last_spawn_r   <= pick_s;
              gap_cnt_r      <= 8'd0;
            end else if ((div_cnt_r == (cur_div_r - 32'd1)) && (gap_cnt_r != SPAWN_GAP_W)) begin
              gap_cnt_r <= gap_cnt_r + 8'd1;
            end else begin
              gap_cnt_r <= gap_cnt_r;
            end
          end
        end
        ST_HALT: begin
          running_r <= 1'b0;
          if (!bus.enable) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_HALT;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          running_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fall_tick    = fall_tick_r;
  assign bus.spawn        = spawn_r;
  assign bus.spawn_letter = spawn_letter_r;
  assign bus.score_inc    = score_inc_r;
  assign bus.running      = running_r;
endmodule

// File: tb/tb_column_scheduler.sv
// Directed bench for column_scheduler with small divider parameters:
// tick/spawn sequences by hand plus a per-cycle table for the score arbiter and HALT/IDLE.
module tb_column_scheduler;
  logic clock = 1'b0;
  logic reset_signal = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  logic [7:0] m_lfsr;
  logic [7:0] m_prev;

  column_scheduler_if bus();

  column_scheduler #(
    .TICK_DIV(32'd10), .MIN_DIV(32'd4), .DIV_STEP(32'd2),
    .SCORE_STEP(32'd4), .SPAWN_GAP(32'd3), .LFSR_SEED(8'hA5)
  ) dut (
    .clock(clock),
    .reset_signal(reset_signal),
    .bus(bus)
  );

  always #5 clock = ~clock;

  // Reference LFSR; m_prev is the value the DUT held just before the latest edge.
  always @(posedge clock or posedge reset_signal) begin
    if (reset_signal) begin
      m_lfsr <= 8'hA5;
      m_prev <= 8'hA5;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'b1011_1000)};
    end
  end

  typedef struct packed {
    logic       en;
    logic [2:0] busy;
    logic [2:0] corr;
    logic [2:0] gover;
    logic       exp_inc;
    logic       exp_run;
    logic       quiet;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (bus.fall_tick) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int n;
    logic [2:0] exp_sp;

    vecs[0]  = '{1'b1, 3'b111, 3'b101, 3'b000, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 3'b111, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 3'b111, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 3'b111, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 3'b111, 3'b001, 3'b000, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 3'b111, 3'b001, 3'b000, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 3'b111, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 3'b111, 3'b111, 3'b000, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 3'b111, 3'b010, 3'b000, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 3'b111, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 3'b111, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 3'b111, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 3'b000, 3'b100, 3'b010, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 3'b000, 3'b011, 3'b000, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 3'b000, 3'b010, 3'b000, 1'b0, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1};

    bus.enable    = 1'b0;
    bus.score     = 8'd0;
    bus.col_busy  = 3'b000;
    bus.correct   = 3'b000;
    bus.game_over = 3'b000;

    #2 reset_signal = 1'b1;
    #1;
    chk("rst_running", 32'(bus.running), 32'd0);
    chk("rst_tick", 32'(bus.fall_tick), 32'd0);
    chk("rst_spawn", 32'(bus.spawn), 32'd0);
    chk("rst_letter", 32'(bus.spawn_letter), 32'd0);
    chk("rst_inc", 32'(bus.score_inc), 32'd0);
    step();
    step();
    reset_signal = 1'b0;
    step();
    chk("idle_running", 32'(bus.running), 32'd0);

    // RUN entry, base period 10 and round-robin spawns after ticks 3, 6 and 9.
    bus.enable = 1'b1;
    step();
    chk("run_entry", 32'(bus.running), 32'd1);
    for (int c = 1; c <= 92; c++) begin
      step();
      chk("tick_period10", 32'(bus.fall_tick), 32'((c % 10) == 0));
      exp_sp = (c == 31) ? 3'b001 : (c == 61) ? 3'b010 : (c == 91) ? 3'b100 : 3'b000;
      chk("spawn_rr", 32'(bus.spawn), 32'(exp_sp));
      if (exp_sp != 3'b000) chk("spawn_letter", 32'(bus.spawn_letter), 32'(m_prev));
    end

    // Score change mid-period keeps the running period, later periods shrink and floor at 4.
    bus.col_busy = 3'b111;
    bus.score    = 8'd8;
    wait_tick(n); chk("period_kept", 32'(n), 32'd8);
    wait_tick(n); chk("period_6a", 32'(n), 32'd6);
    wait_tick(n); chk("period_6b", 32'(n), 32'd6);
    bus.score = 8'd200;
    wait_tick(n); chk("period_6c", 32'(n), 32'd6);
    wait_tick(n); chk("period_floor_a", 32'(n), 32'd4);
    wait_tick(n); chk("period_floor_b", 32'(n), 32'd4);

    // All columns busy past the gap; freeing column 1 spawns there on the very next cycle.
    step();
    chk("busy_hold", 32'(bus.spawn), 32'd0);
    bus.col_busy = 3'b101;
    step();
    chk("free_spawn", 32'(bus.spawn), 32'b010);
    chk("free_letter", 32'(bus.spawn_letter), 32'(m_prev));
    bus.col_busy = 3'b111;
    step();
    chk("spawn_pulse", 32'(bus.spawn), 32'd0);

    // Per-cycle table: arbiter, merge of repeat pulses, game_over priority, HALT and IDLE.
    for (int i = 0; i < 19; i++) begin
      bus.enable    = vecs[i].en;
      bus.col_busy  = vecs[i].busy;
      bus.correct   = vecs[i].corr;
      bus.game_over = vecs[i].gover;
      step();
      chk($sformatf("vec%0d_inc", i), 32'(bus.score_inc), 32'(vecs[i].exp_inc));
      chk($sformatf("vec%0d_run", i), 32'(bus.running), 32'(vecs[i].exp_run));
      chk($sformatf("vec%0d_spawn", i), 32'(bus.spawn), 32'd0);
      if (vecs[i].quiet) chk($sformatf("vec%0d_tick", i), 32'(bus.fall_tick), 32'd0);
    end
    bus.correct = 3'b000;

    // Re-entry reloads the base period regardless of score, then reset mid-RUN.
    bus.enable = 1'b1;
    step();
    chk("reentry", 32'(bus.running), 32'd1);
    wait_tick(n); chk("reentry_period", 32'(n), 32'd10);
    wait_tick(n); chk("reentry_floor", 32'(n), 32'd4);
    chk("pre_reset_tick", 32'(bus.fall_tick), 32'd1);
    #2 reset_signal = 1'b1;
    #1;
    chk("async_running", 32'(bus.running), 32'd0);
    chk("async_tick", 32'(bus.fall_tick), 32'd0);
    chk("async_spawn", 32'(bus.spawn), 32'd0);
    chk("async_letter", 32'(bus.spawn_letter), 32'd0);
    chk("async_inc", 32'(bus.score_inc), 32'd0);
    step();
    reset_signal = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
